dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Shares the single DRAM user port (the MIG-wrapper command/data interface: ren/wen/addr/data/mask/busy/data_valid) between two requesters, e.g. instruction-side and data-side memory masters of the RiscV core.
- Arbitration is round-robin with one transaction outstanding at a time.
- Commands are held stable until the DRAM accepts them.
- Read data is routed back to the owning requester.
- A watchdog terminates reads that never return.

## Interface
- APP_ADDR_WIDTH, 28: DRAM app address width; the port address is APP_ADDR_WIDTH-1 bits.
- APP_DATA_WIDTH, 128: data beat width.
- APP_MASK_WIDTH, 16: byte-mask width (APP_DATA_WIDTH/8).
- TIMEOUT_CYCLES, 4096: maximum read wait before abort.

Ports:
- clock  in  1  sole clock, the DRAM wrapper's user clock.
- reset  in  1  synchronous, active-high.
- req_ren  in  [1:0]  read request per requester.
- req_wen  in  [1:0]  write request per requester.
- req_addr  in  [1:0][APP_ADDR_WIDTH-2:0]  request address.
- req_wdata  in  [1:0][APP_DATA_WIDTH-1:0]  write data.
- req_wmask  in  [1:0][APP_MASK_WIDTH-1:0]  write mask, passed through unchanged.
- req_ack  out  [1:0]  one-cycle completion pulse.
- req_err  out  1  qualifies req_ack; 1 means the read timed out.
- req_rdata  out  APP_DATA_WIDTH  read data, valid with req_ack.
- dram_ren, dram_wen  out  1  command to the DRAM.
- dram_addr  out  APP_ADDR_WIDTH-1  command address.
- dram_wdata  out  APP_DATA_WIDTH  command write data.
- dram_wmask  out  APP_MASK_WIDTH  command write mask.
- dram_user_busy  out  1  constant 0; read data is always captured.
- dram_init_calib_complete  in  1  no grants while 0.
- dram_rdata  in  APP_DATA_WIDTH  read data from the DRAM.
- dram_rdata_valid  in  1  read data strobe.
- dram_busy  in  1  DRAM cannot accept a command this cycle.

## Operation
- States: IDLE, ISSUE, WAIT_READ, DONE.
- **IDLE**
  - A requester is eligible when its ren or wen is high and dram_init_calib_complete is 1.
  - One eligible requester: grant it. Both eligible: grant the one not equal to last_grant.
  - On grant: latch owner, op, addr, wdata and wmask; set last_grant to owner; go to ISSUE.
  - If ren and wen are both high on a requester, the request is a read; wen is ignored.
- **ISSUE**
  - Drive dram_ren or dram_wen from the latched op, with the latched fields.
  - A cycle with the command high and dram_busy 0 is the acceptance.
  - Write accepted: go to DONE. Read accepted: go to WAIT_READ and clear the timeout counter.
  - dram_busy 1: hold the command and fields unchanged.
- **WAIT_READ**
  - Commands are low. The counter increments every cycle.
  - On dram_rdata_valid: capture dram_rdata into req_rdata, set err=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid: set err=1, go to DONE. req_rdata is unchanged.
- **DONE**
  - req_ack[owner]=1 for exactly one cycle, with req_err set as above.
  - Next state is IDLE. The requester must drop its request in the cycle after ack.
- dram_rdata_valid outside WAIT_READ is discarded; this covers late data after a timeout or a reset.
- req_rdata holds its last captured value until the next capture.

## Timing
- Reset values: state IDLE; last_grant=1, so requester 0 wins first after reset; all dram_* outputs 0; req_ack 0; req_err 0; req_rdata 0; counter 0.
- Reset in any state takes effect in the next cycle and abandons the in-flight transaction. No ack is issued for it.
- Request seen in IDLE at cycle N: command is high from N+1.
- Write, with no busy: accepted at N+1, DONE/ack at N+2, IDLE at N+3. Back-to-back throughput is one transaction per 3 cycles.
- Read: ack occurs one cycle after the dram_rdata_valid cycle.
- Every dram_* output and req_* output is registered. No combinational path runs from inputs to outputs.
- Fairness: with both requesters requesting continuously, grants strictly alternate.

## Structure
- Package dram_arbiter_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, ISSUE, WAIT_READ, DONE};
  - localparam NUM_REQ = 2;
  - the op typedef (OP_READ, OP_WRITE).
- Sub-module dram_arb_rr: two-way round-robin picker, combinational. Inputs are the eligible mask and last_grant; outputs are grant_valid and grant_idx.
- Everything else (FSM, latches, counter) lives in dram_arbiter.

## Test plan
1. Calibration gating: dram_init_calib_complete=0 with req_ren[0]=1 for 10 cycles -> dram_ren stays 0. Raise calibration -> dram_ren=1 one cycle later.
2. Single write: req1 addr 0x0000100, wmask 0xFFFF, dram_busy=0, request at cycle N -> dram_wen=1 only at N+1 with matching fields; req_ack=2'b10 at N+2; req_err=0.
3. Simultaneous reads after reset: DRAM returns 128'hA5A5… for the first read and 128'h5A5A… for the second -> requester 0 served first; req_rdata and ack routing are correct; the second grant goes to requester 1.
4. Backpressure: dram_busy=1 for 5 cycles during ISSUE -> dram_ren and dram_addr held constant for 6 cycles; exactly one acceptance; exactly one ack.
5. Timeout: a read with no dram_rdata_valid -> ack with req_err=1 exactly TIMEOUT_CYCLES cycles after acceptance. A late valid afterwards leaves req_rdata unchanged and produces no ack.
6. Reset mid-read: reset asserted in WAIT_READ -> all outputs 0 in the next cycle; a subsequent dual request grants requester 0 first.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the two-requester DRAM user-port arbiter.
// Contents:
//   NUM_REQ  number of requesters sharing the port
//   state_t  arbiter FSM states
//   op_t     latched command type of the transaction in flight
package dram_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_READ,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/dram_arb_rr.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   eligible     in   per-requester eligibility mask
//   last_grant   in   index of the most recently granted requester
//   grant_valid  out  at least one requester is eligible
//   grant_idx    out  requester to grant; on a tie, the one that did not win last
module dram_arb_rr
  import dram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               last_grant,
  output logic               grant_valid,
  output logic               grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    grant_idx   = 1'b0;
    case (eligible)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM user port between two requesters, one transaction at a time.
// Ports:
//   clock, reset              user clock; synchronous active-high reset
//   req_ren/req_wen           per-requester read/write request (read wins if both)
//   req_addr/wdata/wmask      per-requester command fields
//   req_ack                   one-cycle completion pulse to the owner
//   req_err                   with req_ack: 1 when the read timed out
//   req_rdata                 last captured read data
//   dram_ren/wen/addr/wdata/wmask   registered command to the DRAM
//   dram_user_busy            tied 0, read data is always taken
//   dram_init_calib_complete  no grants until calibration is done
//   dram_rdata/rdata_valid    read return path
//   dram_busy                 DRAM cannot accept a command this cycle
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_REQ-1:0]                       req_ren,
  input  logic [NUM_REQ-1:0]                       req_wen,
  input  logic [NUM_REQ-1:0][APP_ADDR_WIDTH-2:0]   req_addr,
  input  logic [NUM_REQ-1:0][APP_DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][APP_MASK_WIDTH-1:0]   req_wmask,
  output logic [NUM_REQ-1:0]                       req_ack,
  output logic                                     req_err,
  output logic [APP_DATA_WIDTH-1:0]                req_rdata,
  output logic                                     dram_ren,
  output logic                                     dram_wen,
  output logic [APP_ADDR_WIDTH-2:0]                dram_addr,
  output logic [APP_DATA_WIDTH-1:0]                dram_wdata,
  output logic [APP_MASK_WIDTH-1:0]                dram_wmask,
  output logic                                     dram_user_busy,
  input  logic                                     dram_init_calib_complete,
  input  logic [APP_DATA_WIDTH-1:0]                dram_rdata,
  input  logic                                     dram_rdata_valid,
  input  logic                                     dram_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  op_t              op;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic               grant_idx;

  assign eligible       = (req_ren | req_wen) & {NUM_REQ{dram_init_calib_complete}};
  assign cnt_next       = cnt + CNT_W'(1);
  assign dram_user_busy = 1'b0;

  dram_arb_rr u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_READ;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      dram_ren   <= 1'b0;
      dram_wen   <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wmask <= '0;
      req_ack    <= '0;
      req_err    <= 1'b0;
      req_rdata  <= '0;
    end else begin
      req_ack <= '0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_idx;
            last_grant <= grant_idx;
            // Read takes precedence when a requester raises both strobes.
            op         <= req_ren[grant_idx] ? OP_READ : OP_WRITE;
            dram_ren   <= req_ren[grant_idx];
            dram_wen   <= ~req_ren[grant_idx];
            dram_addr  <= req_addr[grant_idx];
            dram_wdata <= req_wdata[grant_idx];
            dram_wmask <= req_wmask[grant_idx];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Command and fields hold until a non-busy cycle accepts them.
          if (!dram_busy) begin
            dram_ren <= 1'b0;
            dram_wen <= 1'b0;
            if (op == OP_WRITE) begin
              req_ack[owner] <= 1'b1;
              req_err        <= 1'b0;
              state          <= DONE;
            end else begin
              cnt   <= '0;
              state <= WAIT_READ;
            end
          end
        end
        WAIT_READ: begin
          cnt <= cnt_next;
          if (dram_rdata_valid) begin
            req_rdata      <= dram_rdata;
            req_err        <= 1'b0;
            req_ack[owner] <= 1'b1;
            state          <= DONE;
          end else if (cnt_next == CNT_LAST) begin
            // Counter reaches its last value on this edge: the ack then lands
            // exactly TIMEOUT_CYCLES cycles after the read was accepted.
            req_err        <= 1'b1;
            req_ack[owner] <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          req_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

  localparam int TO = 64;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic                     clock = 1'b0;
  logic                     s_reset = 1'b1;
  logic [1:0]               s_ren = '0;
  logic [1:0]               s_wen = '0;
  logic [1:0][AW-2:0]       s_addr = '0;
  logic [1:0][DW-1:0]       s_wdata = '0;
  logic [1:0][MW-1:0]       s_wmask = '0;
  logic                     s_calib = 1'b0;
  logic [DW-1:0]            s_rdata = '0;
  logic                     s_valid = 1'b0;
  logic                     s_busy = 1'b0;

  logic [1:0]               req_ack;
  logic                     req_err;
  logic [DW-1:0]            req_rdata;
  logic                     dram_ren;
  logic                     dram_wen;
  logic [AW-2:0]            dram_addr;
  logic [DW-1:0]            dram_wdata;
  logic [MW-1:0]            dram_wmask;
  logic                     dram_user_busy;

  always #5 clock = ~clock;

  dram_arbiter #(
    .APP_ADDR_WIDTH (AW),
    .APP_DATA_WIDTH (DW),
    .APP_MASK_WIDTH (MW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock                    (clock),
    .reset                    (s_reset),
    .req_ren                  (s_ren),
    .req_wen                  (s_wen),
    .req_addr                 (s_addr),
    .req_wdata                (s_wdata),
    .req_wmask                (s_wmask),
    .req_ack                  (req_ack),
    .req_err                  (req_err),
    .req_rdata                (req_rdata),
    .dram_ren                 (dram_ren),
    .dram_wen                 (dram_wen),
    .dram_addr                (dram_addr),
    .dram_wdata               (dram_wdata),
    .dram_wmask               (dram_wmask),
    .dram_user_busy           (dram_user_busy),
    .dram_init_calib_complete (s_calib),
    .dram_rdata               (s_rdata),
    .dram_rdata_valid         (s_valid),
    .dram_busy                (s_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level model: one transaction in flight, tracked by timestamps.
  bit            m_txn = 0;      // a transaction owns the port
  bit            m_cmd = 0;      // command not yet accepted
  bit            m_rd = 0;
  bit            m_owner = 0;
  bit            m_last = 1;
  bit            m_err = 0;
  int            m_accept = -100;
  int            m_ack_at = -1;  // cycle of the ack pulse, -1 while a read is outstanding
  logic          e_ren = 0, e_wen = 0, e_err = 0;
  logic [1:0]    e_ack = '0;
  logic [AW-2:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  logic [MW-1:0] e_wmask = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Predicts the outputs of the next cycle from this cycle's inputs.
  task automatic model_update();
    logic [1:0] elig;
    bit         pick;
    if (s_reset) begin
      m_txn = 0; m_cmd = 0; m_last = 1; m_err = 0; m_ack_at = -1;
      e_rdata = '0;
    end else if (!m_txn) begin
      elig = (s_ren | s_wen) & {2{s_calib}};
      if (elig != 2'b00) begin
        pick = (elig == 2'b11) ? !m_last : elig[1];
        m_txn = 1; m_cmd = 1; m_owner = pick; m_last = pick;
        m_rd = s_ren[pick];
        e_addr = s_addr[pick]; e_wdata = s_wdata[pick]; e_wmask = s_wmask[pick];
      end
    end else if (m_cmd) begin
      if (!s_busy) begin
        m_cmd = 0; m_accept = cyc;
        if (m_rd) m_ack_at = -1;
        else begin m_ack_at = cyc + 1; m_err = 0; end
      end
    end else if (m_ack_at >= 0) begin
      if (m_ack_at == cyc) m_txn = 0;
    end else if (s_valid) begin
      e_rdata = s_rdata; m_err = 0; m_ack_at = cyc + 1;
    end else if (cyc - m_accept == TO - 1) begin
      m_err = 1; m_ack_at = cyc + 1;
    end
    e_ren = m_txn && m_cmd && m_rd;
    e_wen = m_txn && m_cmd && !m_rd;
    e_ack = (m_txn && m_ack_at == cyc + 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    e_err = m_err;
  endtask

  task automatic compare();
    chk("dram_ren", dram_ren, e_ren);
    chk("dram_wen", dram_wen, e_wen);
    chk("req_ack", req_ack, e_ack);
    chk("req_rdata", req_rdata, e_rdata);
    chk("dram_user_busy", dram_user_busy, 0);
    if (e_ack != 2'b00) chk("req_err", req_err, e_err);
    if (e_ren || e_wen) begin
      chk("dram_addr", dram_addr, e_addr);
      chk("dram_wdata", dram_wdata, e_wdata);
      chk("dram_wmask", dram_wmask, e_wmask);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    cyc++;
    compare();
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n_hi, n_ack, early;
    logic [DW-1:0] held;
    bit [1:0] want, rdb, wrb, prev_ack;
    int seen_accept, rd_delay;
    bit waiting;

    // Reset state
    step(); step();
    chk("rst_ren", dram_ren, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_rdata", req_rdata, 0);

    // 1. Calibration gating
    s_reset = 0; s_calib = 0; s_ren = 2'b01; s_addr[0] = 27'h0000abc;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("calib_gate_ren", dram_ren, 0);
    end
    s_calib = 1;
    step();
    chk("calib_ren_up", dram_ren, 1);
    step();
    s_valid = 1; s_rdata = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    step();
    chk("calib_ack", req_ack, 2'b01);
    s_valid = 0;
    step();
    s_ren = 2'b00;
    step();

    // 2. Single write from requester 1
    s_wen = 2'b10; s_addr[1] = 27'h0000100; s_wmask[1] = 16'hffff;
    s_wdata[1] = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    step();
    chk("wr_wen", dram_wen, 1);
    chk("wr_addr", dram_addr, 27'h0000100);
    chk("wr_wmask", dram_wmask, 16'hffff);
    step();
    chk("wr_wen_low", dram_wen, 0);
    chk("wr_ack", req_ack, 2'b10);
    chk("wr_err", req_err, 0);
    step();
    s_wen = 2'b00;
    step();

    // 3. Simultaneous reads after reset
    s_reset = 1; step(); s_reset = 0;
    s_ren = 2'b11; s_addr[0] = 27'h0000200; s_addr[1] = 27'h0000300;
    step();
    chk("dual_first_addr", dram_addr, 27'h0000200);
    step();
    s_valid = 1; s_rdata = {16{8'ha5}};
    step();
    chk("dual_ack0", req_ack, 2'b01);
    chk("dual_rdata0", req_rdata, {16{8'ha5}});
    s_valid = 0;
    step();
    s_ren = 2'b10;
    step();
    chk("dual_second_ren", dram_ren, 1);
    chk("dual_second_addr", dram_addr, 27'h0000300);
    step();
    s_valid = 1; s_rdata = {16{8'h5a}};
    step();
    chk("dual_ack1", req_ack, 2'b10);
    chk("dual_rdata1", req_rdata, {16{8'h5a}});
    s_valid = 0;
    step();
    s_ren = 2'b00;
    step();

    // 4. Backpressure: busy for 5 cycles of ISSUE
    s_ren = 2'b01; s_addr[0] = 27'h0000444; s_busy = 1;
    step();
    n_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (dram_ren && dram_addr == 27'h0000444) n_hi++;
      step();
    end
    if (dram_ren && dram_addr == 27'h0000444) n_hi++;
    s_busy = 0;
    step();
    if (dram_ren) n_hi++;
    chk("bp_held_cycles", n_hi, 6);
    s_valid = 1; s_rdata = 128'hcafe;
    step();
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (req_ack[0]) n_ack++;
      s_valid = 0;
      if (i >= 1) s_ren = 2'b00;
      step();
    end
    chk("bp_one_ack", n_ack, 1);

    // 5. Timeout
    held = 128'hcafe;
    s_ren = 2'b10; s_addr[1] = 27'h0000555;
    step();
    step();
    early = 0;
    for (int i = 0; i < TO - 1; i++) begin
      if (req_ack != 2'b00) early++;
      step();
    end
    chk("to_no_early_ack", early, 0);
    chk("to_ack", req_ack, 2'b10);
    chk("to_err", req_err, 1);
    chk("to_rdata_held", req_rdata, held);
    step();
    s_ren = 2'b00; s_valid = 1; s_rdata = 128'hbad;
    step();
    chk("late_no_ack", req_ack, 0);
    chk("late_rdata_held", req_rdata, held);
    s_valid = 0;
    step();
    chk("late_no_ack2", req_ack, 0);

    // 6. Reset mid-read
    s_ren = 2'b01; s_addr[0] = 27'h0000666;
    step();
    step();
    s_reset = 1; s_ren = 2'b11; s_addr[1] = 27'h0000777; s_valid = 1; s_rdata = 128'h1;
    step();
    chk("rst_mid_ren", dram_ren, 0);
    chk("rst_mid_ack", req_ack, 0);
    chk("rst_mid_rdata", req_rdata, 0);
    chk("rst_mid_addr", dram_addr, 0);
    s_reset = 0; s_valid = 0;
    step();
    chk("rst_mid_regrant_addr", dram_addr, 27'h0000666);

    // Randomized traffic against the model
    s_reset = 1; s_ren = '0; s_wen = '0;
    step();
    s_reset = 0;
    want = '0; rdb = '0; wrb = '0; prev_ack = '0;
    seen_accept = -100; rd_delay = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (prev_ack[r]) want[r] = 0;
        else if (!want[r] && $urandom_range(0, 3) == 0) begin
          want[r] = 1;
          rdb[r] = 1'($urandom_range(0, 1));
          wrb[r] = rdb[r] ? 1'($urandom_range(0, 1)) : 1'b1;
          s_addr[r] = 27'($urandom);
          s_wdata[r] = rnd128();
          s_wmask[r] = 16'($urandom);
        end
        s_ren[r] = want[r] & rdb[r];
        s_wen[r] = want[r] & wrb[r];
      end
      prev_ack = e_ack;
      waiting = m_txn && !m_cmd && (m_ack_at < 0);
      if (waiting && m_accept != seen_accept) begin
        seen_accept = m_accept;
        rd_delay = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 6));
      end
      s_rdata = rnd128();
      s_valid = waiting ? (cyc - m_accept - 1 >= rd_delay) : ($urandom_range(0, 15) == 0);
      s_busy = ($urandom_range(0, 2) == 0);
      s_calib = ($urandom_range(0, 19) != 0);
      s_reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
